// File: rtl/store_queue_ctrl.sv
// store_queue_ctrl: in-order store queue that sizes, aligns and drains MEM-stage stores to data memory
// Ports:
//   i_clk, i_reset                 clock, synchronous active-high reset
//   i_st_valid/size/addr/data      store offered by the MEM stage
//   o_st_stall                     queue full, pipeline must hold the store
//   o_st_misalign                  one-cycle pulse: last offered store was misaligned and dropped
//   i_ld_valid, i_ld_addr          load probe; o_ld_conflict flags a pending store to the same word
//   o_mem_req/addr/wdata/be        write request to data memory, held stable until i_mem_ack
//   i_mem_ack                      memory accepted the request this cycle
//   o_empty, o_count               queue occupancy
module store_queue_ctrl #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32
) (
   input  logic                      i_clk,
   input  logic                      i_reset,
   input  logic                      i_st_valid,
   input  logic [1:0]                i_st_size,
   input  logic [ADDR_W-1:0]         i_st_addr,
   input  logic [31:0]               i_st_data,
   output logic                      o_st_stall,
   output logic                      o_st_misalign,
   input  logic                      i_ld_valid,
   input  logic [ADDR_W-1:0]         i_ld_addr,
   output logic                      o_ld_conflict,
   output logic                      o_mem_req,
   output logic [ADDR_W-1:0]         o_mem_addr,
   output logic [31:0]               o_mem_wdata,
   output logic [3:0]                o_mem_be,
   input  logic                      i_mem_ack,
   output logic                      o_empty,
   output logic [$clog2(DEPTH):0]    o_count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   typedef enum logic {S_IDLE, S_REQ} state_t;
   state_t             r_state;
   logic [ADDR_W-3:0]  r_q_addr [DEPTH];
   logic [31:0]        r_q_data [DEPTH];
   logic [3:0]         r_q_be   [DEPTH];
   logic [DEPTH-1:0]   r_q_valid;
   logic [PW-1:0]      r_wr_ptr, r_rd_ptr;
   logic [CW-1:0]      r_count;
   logic               r_misalign, r_mem_req;
   logic [ADDR_W-1:0]  r_mem_addr;
   logic [31:0]        r_mem_wdata;
   logic [3:0]         r_mem_be;
   logic               w_is_word, w_is_half, w_aligned, w_enq, w_pop, w_bypass, w_hit;
   logic [3:0]         w_be;
   logic [31:0]        w_data;
   logic [PW-1:0]      w_nxt_idx;
   logic [CW-1:0]      w_cnt_nxt;
   logic               w_unused;
   assign w_is_word  = (i_st_size == 2'b00) | (i_st_size == 2'b11);
   assign w_is_half  = (i_st_size == 2'b01);
   assign w_aligned  = w_is_word ? (i_st_addr[1:0] == 2'b00) : (w_is_half ? !i_st_addr[0] : 1'b1);
   assign w_be       = w_is_word ? 4'b1111 : (w_is_half ? 4'b0011 << i_st_addr[1:0] : 4'b0001 << i_st_addr[1:0]);
   assign w_data     = w_is_word ? i_st_data : (w_is_half ? {2{i_st_data[15:0]}} : {4{i_st_data[7:0]}});
   // stall comes from the registered count only, so mem_ack never reaches the pipeline combinationally
   assign o_st_stall = (r_count == CW'(DEPTH));
   assign w_enq      = i_st_valid & !o_st_stall & w_aligned;
   assign w_pop      = (r_state == S_REQ) & i_mem_ack;
   assign w_cnt_nxt  = r_count + CW'(w_enq) - CW'(w_pop);
   assign w_nxt_idx  = r_rd_ptr + PW'(1);
   // popping the last entry while one is enqueued: the next head is still on the input bus
   assign w_bypass   = (r_count == CW'(1)) & w_enq;
   assign w_unused   = ^i_ld_addr[1:0];
   always_comb begin
      w_hit = 1'b0;
      for (int i = 0; i < DEPTH; i++)
         if (r_q_valid[i] && r_q_addr[i] == i_ld_addr[ADDR_W-1:2]) w_hit = 1'b1;
   end
   assign o_ld_conflict = i_ld_valid & w_hit;
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_q_addr[i] <= '0;
            r_q_data[i] <= '0;
            r_q_be[i]   <= '0;
         end
         r_q_valid   <= '0;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_misalign  <= 1'b0;
         r_state     <= S_IDLE;
         r_mem_req   <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_be    <= '0;
      end else begin
         r_misalign <= i_st_valid & !o_st_stall & !w_aligned;
         if (w_pop) begin
            r_q_valid[r_rd_ptr] <= 1'b0;
            r_rd_ptr            <= w_nxt_idx;
         end
         if (w_enq) begin
            r_q_addr[r_wr_ptr]  <= i_st_addr[ADDR_W-1:2];
            r_q_data[r_wr_ptr]  <= w_data;
            r_q_be[r_wr_ptr]    <= w_be;
            r_q_valid[r_wr_ptr] <= 1'b1;
            r_wr_ptr            <= r_wr_ptr + PW'(1);
         end
         r_count <= w_cnt_nxt;
         case (r_state)
            S_IDLE: if (r_count != '0) begin
               r_state     <= S_REQ;
               r_mem_req   <= 1'b1;
               r_mem_addr  <= {r_q_addr[r_rd_ptr], 2'b00};
               r_mem_wdata <= r_q_data[r_rd_ptr];
               r_mem_be    <= r_q_be[r_rd_ptr];
            end
            S_REQ: if (i_mem_ack) begin
               if (w_cnt_nxt != '0) begin
                  r_mem_addr  <= w_bypass ? {i_st_addr[ADDR_W-1:2], 2'b00} : {r_q_addr[w_nxt_idx], 2'b00};
                  r_mem_wdata <= w_bypass ? w_data : r_q_data[w_nxt_idx];
                  r_mem_be    <= w_bypass ? w_be : r_q_be[w_nxt_idx];
               end else begin
                  r_state   <= S_IDLE;
                  r_mem_req <= 1'b0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
   assign o_st_misalign = r_misalign;
   assign o_mem_req     = r_mem_req;
   assign o_mem_addr    = r_mem_addr;
   assign o_mem_wdata   = r_mem_wdata;
   assign o_mem_be      = r_mem_be;
   assign o_count       = r_count;
   assign o_empty       = (r_count == '0);
endmodule

// File: doc/store_queue_ctrl.md
Name: store_queue_ctrl

Overview:
Sequences stores from the MEM stage into data memory through a small in-order store queue. Each store is sized (word, half or byte), checked for alignment, and lane-aligned with byte enables. Entries drain to memory over a req/ack handshake. The block stalls the pipeline when the queue is full and flags loads that hit a word still pending in the queue.

Parameters:
DEPTH, 4, queue entries; power of two, minimum 2
ADDR_W, 32, byte address width

Ports:
Clk  input  1  pipeline clock; all state updates on rising edge
Reset  input  1  synchronous, active-high reset
st_valid  input  1  MEM stage presents a store this cycle
st_size  input  2  00 = sw, 01 = sh, 10 = sb, 11 = treated as sw
st_addr  input  ADDR_W  byte address of the store
st_data  input  32  unaligned rt value (data in low bits)
st_stall  output  1  queue full; store not accepted, pipeline must hold
st_misalign  output  1  registered one-cycle pulse: last offered store was misaligned and dropped
ld_valid  input  1  MEM stage presents a load
ld_addr  input  ADDR_W  load byte address
ld_conflict  output  1  combinational; a queued entry matches ld_addr[ADDR_W-1:2]
mem_req  output  1  write request to data memory
mem_addr  output  ADDR_W  word address of the request; bits [1:0] = 00
mem_wdata  output  32  lane-aligned write data
mem_be  output  4  byte enables; bit i = byte lane i (little-endian)
mem_ack  input  1  memory accepted the request this cycle
empty  output  1  queue holds no entries
count  output  log2(DEPTH)+1  number of queued entries

Behaviour:
- Reset: all entries invalid; rd/wr pointers = 0; count = 0; empty = 1; st_stall = 0; st_misalign = 0; mem_req = 0; mem_addr, mem_wdata and mem_be = 0; FSM in IDLE. Reset mid-handshake drops the outstanding request and all queued entries.
- st_stall = (count == DEPTH), decoded from registers only, with no combinational path from mem_ack.
- Accept condition: st_valid & !st_stall & aligned.
  - Word (00/11): aligned if addr[1:0] == 0; be = 1111; data = st_data.
  - Half (01): aligned if addr[0] == 0; be = 0011 << addr[1:0]; data = {2{st_data[15:0]}}.
  - Byte (10): always aligned; be = 0001 << addr[1:0]; data = {4{st_data[7:0]}}.
- Misaligned store with st_valid & !st_stall: not enqueued; st_misalign = 1 on the next cycle only.
- Accepted entry stores {addr[ADDR_W-1:2], 00}, data and be, and is written at wr_ptr. Pointers wrap modulo DEPTH.
- Drain FSM:
  - IDLE: mem_req = 0. Go to REQ when count != 0; head fields load into the output registers on that transition.
  - REQ: mem_req = 1; mem_addr, mem_wdata and mem_be must stay stable until mem_ack.
  - On mem_ack: pop head (rd_ptr++, count--). If entries remain after the pop (including one enqueued the same cycle), stay in REQ and present the next head on the following cycle without a gap. Otherwise go to IDLE and deassert mem_req on the next cycle.
  - An entry becomes visible to the drain path no earlier than the cycle after it is enqueued, so minimum enqueue-to-mem_req latency is 2 cycles.
- Simultaneous enqueue and pop: count is unchanged. When full, st_stall still holds this cycle because it is computed from registered count. The slot frees on the next cycle.
- ld_conflict: compares ld_addr word address against every valid entry, including the head being issued. It is 0 when ld_valid = 0. An entry popped this cycle still counts for conflict in this cycle. Resolving the conflict (stall or forward) is the consumer's job.
- Ordering is strictly FIFO, with no store merging or combining.
- The block must not assert mem_req while count == 0.

Test Plan:
- Reset then idle: Reset = 1 for 2 cycles -> empty = 1, count = 0, mem_req = 0, st_stall = 0.
- sb to 0x00000103, data 0x000000AB, mem_ack tied 1 -> mem_req 2 cycles later with mem_addr = 0x00000100, mem_be = 1000, mem_wdata = 0xABABABAB; one request only.
- sh to 0x00000202, data 0x1234 -> mem_be = 1100, mem_wdata = 0x12341234. sw to 0x00000201 -> no enqueue, st_misalign pulses 1 cycle, count unchanged.
- mem_ack held 0, 5 back-to-back sw (DEPTH = 4) -> count = 4, st_stall = 1, 5th store held. Release mem_ack -> 4 entries drain in order with back-to-back mem_req and no idle cycle, then the 5th is accepted and drains.
- sw to 0x00000300 pending (mem_ack = 0), load from 0x00000302 -> ld_conflict = 1. Load from 0x00000304 -> 0. After drain, load from 0x00000302 -> 0.
- Reset asserted while mem_req = 1 with 3 entries queued -> next cycle mem_req = 0, count = 0, no further requests.
